// File: rtl/video_lpf_ram_ctrl_if.sv
// Monitor-side view of the LPF core's input AXI4-Stream.
//   tuser  : start of frame (tuser[0])
//   tlast  : end of line
//   tvalid : stream valid
//   tready : stream ready
// master : the stream endpoint (drives all signals)
// slave  : observer (samples all signals, drives none)
interface video_lpf_ram_ctrl_if;
  logic tuser;
  logic tlast;
  logic tvalid;
  logic tready;

  modport master (
    output tuser,
    output tlast,
    output tvalid,
    output tready
  );

  modport slave (
    input tuser,
    input tlast,
    input tvalid,
    input tready
  );
endinterface

// File: rtl/video_lpf_ram_ctrl.sv
// Frame-synchronous sequencer for the video LPF RAM core's alpha parameter.
// It observes the core's input stream and commits alpha/state changes only at
// frame boundaries. After enable or clear it primes the core's frame RAM with
// PRIME_FRAMES unfiltered frames (alpha = 0) before filtering starts.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   cfg_enable_i       level, 1 = filtering requested
//   cfg_alpha_i        requested alpha, captured on cfg_update_i
//   cfg_update_i       pulse: capture cfg_alpha_i as pending alpha
//   cfg_clear_i        pulse: request a re-prime
//   param_height_i     lines per frame (0 treated as 1)
//   mon                observed stream (slave modport)
//   param_alpha_o      registered alpha to the core
//   status_state_o     0 = disable, 1 = prime, 2 = run
//   status_busy_o      update or clear still pending
//   frame_count_o      completed frames, wraps
//   sync_err_count_o   start-of-frame seen mid-frame, saturates
module video_lpf_ram_ctrl #(
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned HEIGHT_BITS      = 12,
  parameter int unsigned PRIME_FRAMES     = 2,
  parameter int unsigned FCNT_BITS        = 16,
  parameter int unsigned ECNT_BITS        = 8,
  parameter int unsigned INIT_PARAM_ALPHA = 0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_enable_i,
  input  logic [DATA_BITS-1:0]   cfg_alpha_i,
  input  logic                   cfg_update_i,
  input  logic                   cfg_clear_i,
  input  logic [HEIGHT_BITS-1:0] param_height_i,
  video_lpf_ram_ctrl_if.slave    mon,
  output logic [DATA_BITS-1:0]   param_alpha_o,
  output logic [1:0]             status_state_o,
  output logic                   status_busy_o,
  output logic [FCNT_BITS-1:0]   frame_count_o,
  output logic [ECNT_BITS-1:0]   sync_err_count_o
);

  localparam int unsigned PcntBits = $clog2(PRIME_FRAMES + 1);

  typedef enum logic [1:0] {
    StDisable = 2'd0,
    StPrime   = 2'd1,
    StRun     = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PcntBits-1:0]    prime_cnt_q, prime_cnt_d;
  logic [DATA_BITS-1:0]   param_alpha_q, param_alpha_d;
  logic [DATA_BITS-1:0]   active_alpha_q, active_alpha_d;
  logic [DATA_BITS-1:0]   pend_alpha_q, pend_alpha_d;
  logic                   upd_pend_q, upd_pend_d;
  logic                   clr_pend_q, clr_pend_d;
  logic                   in_frame_q, in_frame_d;
  logic [HEIGHT_BITS-1:0] line_cnt_q, line_cnt_d;
  logic [FCNT_BITS-1:0]   frame_cnt_q, frame_cnt_d;
  logic [ECNT_BITS-1:0]   sync_err_q, sync_err_d;

  logic                   beat, sof, frame_end, bnd;
  logic                   line_end;
  logic [HEIGHT_BITS-1:0] cur_line, last_line;
  logic                   upd_eff, clr_eff;
  logic [DATA_BITS-1:0]   pend_eff;

  // Frame tracking
  always_comb begin
    beat      = mon.tvalid & mon.tready;
    sof       = beat & mon.tuser;
    last_line = (param_height_i == '0) ? '0 : param_height_i - HEIGHT_BITS'(1);
    // An SOF beat restarts the line count; its own tlast closes line 0.
    cur_line  = sof ? '0 : line_cnt_q;
    line_end  = beat & mon.tlast & (sof | in_frame_q);
    frame_end = line_end & (cur_line == last_line);
    bnd       = frame_end | (~in_frame_q & ~sof);

    in_frame_d  = in_frame_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    sync_err_d  = sync_err_q;

    if (sof) begin
      in_frame_d = 1'b1;
      line_cnt_d = '0;
    end
    if (line_end) begin
      line_cnt_d = cur_line + HEIGHT_BITS'(1);
    end
    if (frame_end) begin
      in_frame_d  = 1'b0;
      line_cnt_d  = '0;
      frame_cnt_d = frame_cnt_q + FCNT_BITS'(1);
    end
    if (sof && in_frame_q && (sync_err_q != '1)) begin
      sync_err_d = sync_err_q + ECNT_BITS'(1);
    end
  end

  // Pending requests, sequencer FSM and alpha output
  always_comb begin
    // Requests arriving on the boundary cycle itself are committed right away.
    upd_eff  = upd_pend_q | cfg_update_i;
    clr_eff  = clr_pend_q | cfg_clear_i;
    pend_eff = cfg_update_i ? cfg_alpha_i : pend_alpha_q;

    state_d        = state_q;
    prime_cnt_d    = prime_cnt_q;
    active_alpha_d = active_alpha_q;
    pend_alpha_d   = pend_eff;
    upd_pend_d     = upd_eff;
    clr_pend_d     = clr_eff;
    param_alpha_d  = param_alpha_q;

    if (bnd) begin
      if (upd_eff) begin
        active_alpha_d = pend_eff;
      end
      upd_pend_d = 1'b0;
      // Every path below either consumes the clear or drops to disable, where
      // a clear has no meaning, so it never survives a boundary.
      clr_pend_d = 1'b0;

      unique case (state_q)
        StDisable: begin
          if (cfg_enable_i) begin
            state_d     = StPrime;
            prime_cnt_d = PcntBits'(PRIME_FRAMES);
          end
        end
        StPrime: begin
          if (!cfg_enable_i) begin
            state_d = StDisable;
          end else if (clr_eff) begin
            prime_cnt_d = PcntBits'(PRIME_FRAMES);
          end else if (frame_end) begin
            prime_cnt_d = prime_cnt_q - PcntBits'(1);
            if (prime_cnt_q == PcntBits'(1)) begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (!cfg_enable_i) begin
            state_d = StDisable;
          end else if (clr_eff) begin
            state_d     = StPrime;
            prime_cnt_d = PcntBits'(PRIME_FRAMES);
          end
        end
        default: state_d = StDisable;
      endcase

      param_alpha_d = (state_d == StRun) ? active_alpha_d : '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= StDisable;
      prime_cnt_q    <= '0;
      param_alpha_q  <= '0;
      active_alpha_q <= DATA_BITS'(INIT_PARAM_ALPHA);
      pend_alpha_q   <= '0;
      upd_pend_q     <= 1'b0;
      clr_pend_q     <= 1'b0;
      in_frame_q     <= 1'b0;
      line_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      sync_err_q     <= '0;
    end else begin
      state_q        <= state_d;
      prime_cnt_q    <= prime_cnt_d;
      param_alpha_q  <= param_alpha_d;
      active_alpha_q <= active_alpha_d;
      pend_alpha_q   <= pend_alpha_d;
      upd_pend_q     <= upd_pend_d;
      clr_pend_q     <= clr_pend_d;
      in_frame_q     <= in_frame_d;
      line_cnt_q     <= line_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      sync_err_q     <= sync_err_d;
    end
  end

  assign param_alpha_o    = param_alpha_q;
  assign status_state_o   = state_q;
  assign status_busy_o    = upd_pend_q | clr_pend_q;
  assign frame_count_o    = frame_cnt_q;
  assign sync_err_count_o = sync_err_q;

endmodule

// File: tb/tb_video_lpf_ram_ctrl.sv
module tb_video_lpf_ram_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        cfg_enable;
  logic [7:0]  cfg_alpha;
  logic        cfg_update;
  logic        cfg_clear;
  logic [11:0] param_height;
  logic [7:0]  param_alpha;
  logic [1:0]  status_state;
  logic        status_busy;
  logic [15:0] frame_count;
  logic [7:0]  sync_err_count;

  video_lpf_ram_ctrl_if mif ();

  video_lpf_ram_ctrl #(
    .DATA_BITS       (8),
    .HEIGHT_BITS     (12),
    .PRIME_FRAMES    (2),
    .FCNT_BITS       (16),
    .ECNT_BITS       (8),
    .INIT_PARAM_ALPHA(0)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .cfg_enable_i    (cfg_enable),
    .cfg_alpha_i     (cfg_alpha),
    .cfg_update_i    (cfg_update),
    .cfg_clear_i     (cfg_clear),
    .param_height_i  (param_height),
    .mon             (mif.slave),
    .param_alpha_o   (param_alpha),
    .status_state_o  (status_state),
    .status_busy_o   (status_busy),
    .frame_count_o   (frame_count),
    .sync_err_count_o(sync_err_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] alpha;
    logic [1:0] state;
  } sof_exp_t;

  sof_exp_t   exp_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         track = 1'b0;
  logic [7:0] frame_alpha = 8'h00;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every start-of-frame beat pops one expectation; every
  // other beat of a tracked frame must still carry that frame's alpha.
  always @(negedge aclk) begin
    if (aresetn && mif.tvalid && mif.tready) begin
      if (mif.tuser) begin
        if (exp_q.size() == 0) begin
          chk("sof_unexpected", 1, 0);
        end else begin
          sof_exp_t e;
          e = exp_q.pop_front();
          chk("sof_alpha", param_alpha, e.alpha);
          chk("sof_state", status_state, e.state);
          frame_alpha = e.alpha;
          track = 1'b1;
        end
      end else if (track) begin
        chk("alpha_stable_in_frame", param_alpha, frame_alpha);
      end
    end
  end

  task automatic drive_beat(input bit u, input bit l);
    mif.tvalid = 1'b1;
    mif.tready = 1'b1;
    mif.tuser  = u;
    mif.tlast  = l;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    mif.tvalid = 1'b0;
    mif.tuser  = 1'b0;
    mif.tlast  = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Frame of h lines, two beats per line; optional update/clear pulse on a beat.
  task automatic send_frame(input int h, input logic [7:0] ea, input logic [1:0] es,
                            input int upd_beat, input logic [7:0] upd_val, input int clr_beat);
    sof_exp_t e;
    e.alpha = ea;
    e.state = es;
    exp_q.push_back(e);
    for (int i = 0; i < 2 * h; i++) begin
      cfg_update = (i == upd_beat);
      cfg_alpha  = upd_val;
      cfg_clear  = (i == clr_beat);
      drive_beat(i == 0, (i % 2) == 1);
      cfg_update = 1'b0;
      cfg_clear  = 1'b0;
      if ((i == upd_beat || i == clr_beat) && i < 2 * h - 1) chk("busy_midframe", status_busy, 1);
    end
    track = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] ea, input logic [1:0] es);
    sof_exp_t e;
    e.alpha = ea;
    e.state = es;
    exp_q.push_back(e);
  endtask

  initial begin
    aresetn      = 1'b0;
    cfg_enable   = 1'b0;
    cfg_alpha    = 8'h00;
    cfg_update   = 1'b0;
    cfg_clear    = 1'b0;
    param_height = 12'd4;
    mif.tvalid   = 1'b0;
    mif.tready   = 1'b0;
    mif.tuser    = 1'b0;
    mif.tlast    = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_alpha", param_alpha, 8'h00);
    chk("reset_state", status_state, 0);
    chk("reset_busy", status_busy, 0);
    chk("reset_fcnt", frame_count, 0);
    chk("reset_ecnt", sync_err_count, 0);
    aresetn = 1'b1;
    idle(1);

    // 1: enable with alpha 0x40; two priming frames, third frame filtered
    cfg_enable = 1'b1;
    cfg_alpha  = 8'h40;
    cfg_update = 1'b1;
    idle(1);
    cfg_update = 1'b0;
    chk("t1_busy_bypass", status_busy, 0);
    chk("t1_state_prime", status_state, 1);
    chk("t1_alpha_prime", param_alpha, 8'h00);
    idle(2);
    send_frame(4, 8'h00, 2'd1, -1, 8'h00, -1);
    idle(1);
    send_frame(4, 8'h00, 2'd1, -1, 8'h00, -1);
    idle(1);
    chk("t1_state_run", status_state, 2);
    send_frame(4, 8'h40, 2'd2, -1, 8'h00, -1);
    idle(1);
    chk("t1_fcnt", frame_count, 3);

    // 2: mid-frame update waits for the frame end
    send_frame(4, 8'h40, 2'd2, 3, 8'h80, -1);
    chk("t2_busy_done", status_busy, 0);
    chk("t2_alpha_after", param_alpha, 8'h80);
    idle(1);
    send_frame(4, 8'h80, 2'd2, -1, 8'h00, -1);
    idle(1);

    // 3: update on the frame-end beat, next frame back-to-back
    send_frame(4, 8'h80, 2'd2, 7, 8'hC0, -1);
    send_frame(4, 8'hC0, 2'd2, -1, 8'h00, -1);
    idle(1);

    // 4: clear mid-frame re-primes for two frames
    send_frame(4, 8'hC0, 2'd2, -1, 8'h00, 2);
    idle(1);
    chk("t4_state_prime", status_state, 1);
    send_frame(4, 8'h00, 2'd1, -1, 8'h00, -1);
    idle(1);
    send_frame(4, 8'h00, 2'd1, -1, 8'h00, -1);
    idle(1);
    send_frame(4, 8'hC0, 2'd2, -1, 8'h00, -1);
    idle(1);
    chk("t4_fcnt", frame_count, 11);

    // 5: SOF injected at line 2 restarts the frame
    push_exp(8'hC0, 2'd2);
    drive_beat(1, 0); drive_beat(0, 1);
    drive_beat(0, 0); drive_beat(0, 1);
    push_exp(8'hC0, 2'd2);
    drive_beat(1, 0);
    chk("t5_sync_err", sync_err_count, 1);
    drive_beat(0, 1);
    drive_beat(0, 0); drive_beat(0, 1);
    drive_beat(0, 0); drive_beat(0, 1);
    chk("t5_fcnt_no_inc", frame_count, 11);
    drive_beat(0, 0); drive_beat(0, 1);
    track = 1'b0;
    chk("t5_fcnt_end", frame_count, 12);
    idle(1);
    chk("t5_state", status_state, 2);

    // 6: no handshake means no counting; async reset mid-frame
    for (int i = 0; i < 6; i++) begin
      mif.tvalid = i[0];
      mif.tready = 1'b0;
      mif.tuser  = 1'b1;
      mif.tlast  = 1'b1;
      @(posedge aclk);
      #1;
    end
    idle(1);
    chk("t6_fcnt_noready", frame_count, 12);
    chk("t6_ecnt_noready", sync_err_count, 1);
    push_exp(8'hC0, 2'd2);
    drive_beat(1, 0); drive_beat(0, 1); drive_beat(0, 0);
    track = 1'b0;
    mif.tvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("t6_rst_alpha", param_alpha, 8'h00);
    chk("t6_rst_state", status_state, 0);
    chk("t6_rst_fcnt", frame_count, 0);
    chk("t6_rst_ecnt", sync_err_count, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    drive_beat(0, 1); drive_beat(0, 0); drive_beat(0, 1); drive_beat(0, 1);
    idle(1);
    chk("t6_stray_ignored", frame_count, 0);
    chk("t6_state_prime", status_state, 1);
    send_frame(4, 8'h00, 2'd1, -1, 8'h00, -1);
    idle(1);
    chk("t6_fcnt_restart", frame_count, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
